mux_sel_pipe: RTL and testbench

Parametrised, registered N-channel, W-bit selector. It is the next generation of the ALU operand/result multiplexer. It generalises the fixed 16-bit, 16-input combinational select to configurable width and channel count. It adds per-channel valid/ready handshakes, a 2-entry output skid buffer and an optional round-robin scan mode. It sits between the ALU function units and the MCU result/writeback path.

---
 rtl/mux_sel_pipe.sv | 184 ++++++++++++++++++
 tb/tb_mux_sel_pipe.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux_sel_pipe.sv
// mux_sel_pipe: registered NCH-channel, WIDTH-bit selector with per-channel handshake and 2-entry output skid buffer.
// Round-robin scan mode (mode=1) is built only when MUX_SEL_PIPE_RR_EN is defined; otherwise mode is ignored.
module mux_sel_pipe #(
  parameter int WIDTH = 16,
  parameter int NCH   = 16,
  parameter int SELW  = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic [SELW-1:0]      sel,
  input  logic                 sel_load,
  input  logic                 mode,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch,
  output logic                 out_valid,
  input  logic                 out_ready
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } buf_state_e;

  buf_state_e       state_r;
  buf_state_e       state_nxt_s;
  logic [SELW-1:0]  cur_sel_r;
  logic [SELW-1:0]  grant_s;
  logic             grant_vld_s;
  logic [WIDTH-1:0] grant_data_s;
  logic             sel_ok_s;
  logic             xfer_s;
  logic             pop_s;
  logic             load_head_s;
  logic             load_skid_s;
  logic             shift_skid_s;
  logic [WIDTH-1:0] head_data_r;
  logic [WIDTH-1:0] skid_data_r;
  logic [SELW-1:0]  head_ch_r;
  logic [SELW-1:0]  skid_ch_r;
  logic             out_valid_r;

  assign sel_ok_s     = ({1'b0, sel} < (SELW+1)'(NCH));
  assign grant_data_s = in_data[int'(grant_s)*WIDTH +: WIDTH];
  assign pop_s        = out_valid_r && out_ready;

`ifdef MUX_SEL_PIPE_RR_EN
  localparam int CW = SELW + 2;

  logic [SELW-1:0] last_g_r;
  logic [SELW-1:0] rr_g_s;
  logic            rr_vld_s;
  logic [CW-1:0]   base_s;
  logic [CW-1:0]   sum_s;
  logic [NCH-1:0]  rot_s;

  // Round-robin search: rotate valids so bit 0 is last_g+1, pick lowest set bit, unrotate
  always_comb begin
    base_s   = CW'(last_g_r) + CW'(1);
    rot_s    = NCH'({in_valid, in_valid} >> base_s);
    sum_s    = base_s;
    rr_vld_s = |rot_s;
    for (int j = NCH - 1; j >= 0; j--) begin
      sum_s = rot_s[j] ? (base_s + CW'(j)) : sum_s;
    end
    if (sum_s >= CW'(NCH)) begin
      rr_g_s = SELW'(sum_s - CW'(NCH));
    end else begin
      rr_g_s = SELW'(sum_s);
    end
  end

  assign grant_s     = mode ? rr_g_s : cur_sel_r;
  assign grant_vld_s = mode ? rr_vld_s : in_valid[cur_sel_r];

  // Last granted channel, advanced only by a completed input transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_g_r <= SELW'(NCH - 1);
    end else if (xfer_s) begin
      last_g_r <= grant_s;
    end else begin
      last_g_r <= last_g_r;
    end
  end
`else
  logic unused_mode_s;

  assign unused_mode_s = mode;
  assign grant_s       = cur_sel_r;
  assign grant_vld_s   = in_valid[cur_sel_r];
`endif

  // Fixed-mode select register; out-of-range indices are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_sel_r <= '0;
    end else if (sel_load && sel_ok_s) begin
      cur_sel_r <= sel;
    end else begin
      cur_sel_r <= cur_sel_r;
    end
  end

  // Buffer occupancy state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Buffer occupancy next-state
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_EMPTY: state_nxt_s = xfer_s ? ST_ONE : ST_EMPTY;
      ST_ONE: begin
        if (xfer_s && !pop_s) begin
          state_nxt_s = ST_TWO;
        end else if (!xfer_s && pop_s) begin
          state_nxt_s = ST_EMPTY;
        end else begin
          state_nxt_s = ST_ONE;
        end
      end
      ST_TWO:   state_nxt_s = pop_s ? ST_ONE : ST_TWO;
      default:  state_nxt_s = ST_EMPTY;
    endcase
  end

  // Handshake decode: one-hot ready (held low in reset) and buffer load strobes
  always_comb begin
    in_ready = '0;
    xfer_s   = rst_n && grant_vld_s && (state_r != ST_TWO);
    if (xfer_s) begin
      in_ready[grant_s] = 1'b1;
    end else begin
      in_ready = '0;
    end
    load_head_s  = xfer_s && ((state_r == ST_EMPTY) || ((state_r == ST_ONE) && pop_s));
    load_skid_s  = xfer_s && (state_r == ST_ONE) && !pop_s;
    shift_skid_s = pop_s && (state_r == ST_TWO);
  end

  // Head/skid data registers and registered valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_data_r <= '0;
      head_ch_r   <= '0;
      skid_data_r <= '0;
      skid_ch_r   <= '0;
      out_valid_r <= 1'b0;
    end else begin
      if (load_head_s) begin
        head_data_r <= grant_data_s;
        head_ch_r   <= grant_s;
      end else if (shift_skid_s) begin
        head_data_r <= skid_data_r;
        head_ch_r   <= skid_ch_r;
      end else begin
        head_data_r <= head_data_r;
        head_ch_r   <= head_ch_r;
      end
      if (load_skid_s) begin
        skid_data_r <= grant_data_s;
        skid_ch_r   <= grant_s;
      end else begin
        skid_data_r <= skid_data_r;
        skid_ch_r   <= skid_ch_r;
      end
      out_valid_r <= (state_nxt_s != ST_EMPTY);
    end
  end

  assign out_data  = head_data_r;
  assign out_ch    = head_ch_r;
  assign out_valid = out_valid_r;

endmodule

// File: tb/tb_mux_sel_pipe.sv
// Self-checking bench for mux_sel_pipe: queue-based reference model plus directed literal checks.
module tb_mux_sel_pipe;
  localparam int W  = 16;
  localparam int N  = 16;
  localparam int SW = 4;
  localparam int NB = 12;

`ifdef MUX_SEL_PIPE_RR_EN
  localparam bit RR_BUILT = 1'b1;
  int rr_exp[9] = '{0, 2, 7, 0, 2, 7, 0, 7, 0};
`else
  localparam bit RR_BUILT = 1'b0;
  int rr_exp[9] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid, in_ready;
  logic [SW-1:0]  sel, out_ch;
  logic           sel_load, mode, out_valid, out_ready;
  logic [W-1:0]   out_data;

  logic [NB*W-1:0] in_data_b;
  logic [NB-1:0]   in_valid_b, in_ready_b;
  logic [SW-1:0]   sel_b, out_ch_b;
  logic            sel_load_b, mode_b, out_valid_b, out_ready_b;
  logic [W-1:0]    out_data_b;

  mux_sel_pipe #(.WIDTH(W), .NCH(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .sel_load(sel_load), .mode(mode), .out_data(out_data), .out_ch(out_ch),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  mux_sel_pipe #(.WIDTH(W), .NCH(NB)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(in_data_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .sel(sel_b), .sel_load(sel_load_b), .mode(mode_b), .out_data(out_data_b), .out_ch(out_ch_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] q_data[$];
  int           q_ch[$];
  int           m_sel, m_last;
  logic [W-1:0] rec_data[$];
  int           rec_ch[$];
  bit           rec_en = 1'b0;
  logic [W-1:0] bp_exp[3] = '{16'h0001, 16'h0002, 16'h0003};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    q_data.delete();
    q_ch.delete();
    m_sel  = 0;
    m_last = N - 1;
  endtask

  function automatic int exp_grant();
    if (RR_BUILT && mode) begin
      for (int k = 1; k <= N; k++) begin
        if (in_valid[(m_last + k) % N]) return (m_last + k) % N;
      end
      return -1;
    end
    return in_valid[m_sel] ? m_sel : -1;
  endfunction

  // One clock: compare DUT against model, then advance the model. Entered at posedge+1.
  task automatic tick();
    int g;
    logic [N-1:0] exp_rdy;
    #3;
    g = exp_grant();
    exp_rdy = '0;
    if (g >= 0 && q_data.size() < 2) exp_rdy[g] = 1'b1;
    chk("in_ready", in_ready, exp_rdy);
    chk("out_valid", out_valid, q_data.size() != 0);
    if (q_data.size() != 0) begin
      chk("out_data", out_data, q_data[0]);
      chk("out_ch", out_ch, q_ch[0]);
    end
    if (rec_en && out_valid) rec_ch.push_back(int'(out_ch));
    if (rec_en && out_valid && out_ready) rec_data.push_back(out_data);
    if (q_data.size() != 0 && out_ready) begin
      void'(q_data.pop_front());
      void'(q_ch.pop_front());
    end
    if (exp_rdy != '0) begin
      q_data.push_back(in_data[g*W +: W]);
      q_ch.push_back(g);
      m_last = g;
    end
    if (sel_load && int'(sel) < N) m_sel = int'(sel);
    @(posedge clk);
    #1;
  endtask

  initial begin
    in_data = '0; in_valid = '1; sel = '0; sel_load = 1'b0; mode = 1'b0; out_ready = 1'b1;
    in_data_b = '0; in_valid_b = '0; sel_b = '0; sel_load_b = 1'b0; mode_b = 1'b0; out_ready_b = 1'b1;
    m_reset();

    // reset hold with all channels valid
    repeat (3) @(posedge clk);
    #3;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 16'h0000);
    chk("rst_out_data", out_data, 16'h0000);
    chk("rst_out_ch", out_ch, 4'h0);
    in_data[0 +: W] = 16'h1234;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    chk("first_valid", out_valid, 1'b1);
    chk("first_word", out_data, 16'h1234);
    chk("first_ch", out_ch, 4'h0);

    // fixed select; load happens alongside a ch0 transfer on the old select
    sel = 4'd5; sel_load = 1'b1;
    tick();
    sel_load = 1'b0;
    in_data[5*W +: W] = 16'hA5A5;
    #1;
    chk("fixed_ready", in_ready, 16'h0020);
    tick();
    chk("fixed_data", out_data, 16'hA5A5);
    chk("fixed_ch", out_ch, 4'h5);

    // out-of-range select on the 12-channel instance is ignored
    sel_b = 4'd5; sel_load_b = 1'b1;
    @(posedge clk); #1;
    sel_b = 4'd13;
    @(posedge clk); #1;
    sel_b = 4'd15;
    @(posedge clk); #1;
    sel_load_b = 1'b0;
    in_valid_b = '1;
    in_data_b[5*W +: W] = 16'h5A5A;
    #1;
    chk("ignore_ready", in_ready_b, 12'h020);
    @(posedge clk); #1;
    chk("ignore_ch", out_ch_b, 4'h5);
    chk("ignore_data", out_data_b, 16'h5A5A);
    in_valid_b = '0;

    // backpressure on ch3
    in_valid = '0;
    tick(); tick();
    sel = 4'd3; sel_load = 1'b1;
    tick();
    sel_load = 1'b0;
    out_ready = 1'b0;
    rec_data.delete();
    rec_en = 1'b1;
    in_valid = 16'h0008;
    in_data[3*W +: W] = 16'h0001; tick();
    in_data[3*W +: W] = 16'h0002; tick();
    in_data[3*W +: W] = 16'h0003;
    #1;
    chk("bp_stall", in_ready, 16'h0000);
    tick();
    out_ready = 1'b1;
    tick(); tick();
    in_valid = '0;
    tick(); tick();
    rec_en = 1'b0;
    chk("bp_count", rec_data.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < rec_data.size()) chk("bp_order", rec_data[i], bp_exp[i]);
    end

    // asynchronous reset with buffer full
    out_ready = 1'b0;
    in_valid = 16'h0008;
    in_data[3*W +: W] = 16'hBEEF;
    tick(); tick();
    chk("pre_rst_full", out_valid, 1'b1);
    in_valid = '1;
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_ready", in_ready, 16'h0000);
    m_reset();
    in_valid = '0;
    out_ready = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    tick(); tick(); tick();

    // round-robin over channels 0, 2, 7 then 0, 7
    mode = 1'b1;
    in_data[0*W +: W] = 16'h0100;
    in_data[2*W +: W] = 16'h0102;
    in_data[7*W +: W] = 16'h0107;
    in_valid = 16'h0085;
    rec_ch.delete();
    rec_en = 1'b1;
    repeat (6) tick();
    in_valid = 16'h0081;
    repeat (4) tick();
    rec_en = 1'b0;
    chk("rr_len", rec_ch.size(), 9);
    for (int i = 0; i < 9; i++) begin
      if (i < rec_ch.size()) chk("rr_seq", rec_ch[i], rr_exp[i]);
    end

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) in_data[i*W +: W] = W'($urandom);
      in_valid  = ($urandom_range(0, 3) == 0) ? '1 : N'($urandom & $urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      sel_load  = ($urandom_range(0, 7) == 0);
      sel       = SW'($urandom);
      if ($urandom_range(0, 49) == 0) mode = ~mode;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
